// File: rtl/trolley_system_button_debounce.sv
// trolley_system_button_debounce
// Debounces one raw mechanical push-button and drives the button PIO in_port.
// Also produces one-cycle press, release and long-press strobes.
// A two-flop synchroniser feeds a four-state debounce FSM. All outputs are
// registered. Reset is synchronous and active-low.
module trolley_system_button_debounce #(
  parameter bit ACTIVE_LOW        = 1'b1,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int CNT_W             = 26
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_in,
  output logic button_out,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse,
  output logic held
);

  // Pin level while the button is untouched, and while it is pressed.
  localparam logic IDLE_LEVEL   = ACTIVE_LOW;
  localparam logic ACTIVE_LEVEL = ~ACTIVE_LOW;

  // Terminal counts. Counters stop here and never wrap.
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  // Synchroniser stages: sync_reg[0] samples the pin, sync_reg[1] is safe to use.
  logic [1:0]       sync_reg;
  logic             act;

  state_t           state_reg;
  logic [CNT_W-1:0] db_cnt_reg;
  logic [CNT_W-1:0] hold_cnt_reg;
  logic             button_out_reg;
  logic             pressed_reg;
  logic             press_pulse_reg;
  logic             release_pulse_reg;
  logic             long_press_pulse_reg;
  logic             held_reg;

  // Two-flop synchroniser for the asynchronous pin. It resets to the idle level
  // so that no phantom press appears as reset is released.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_reg <= {IDLE_LEVEL, IDLE_LEVEL};
    end else begin
      sync_reg <= {sync_reg[0], button_in};
    end
  end

  // Normalise the pin polarity: act is 1 while the button is physically pressed.
  assign act = sync_reg[1] ^ ACTIVE_LOW;

  // Debounce FSM. Each bounce restarts db_cnt. hold_cnt measures press duration
  // and is frozen, not cleared, while a release is still unconfirmed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg            <= S_RELEASED;
      db_cnt_reg           <= '0;
      hold_cnt_reg         <= '0;
      button_out_reg       <= IDLE_LEVEL;
      pressed_reg          <= 1'b0;
      press_pulse_reg      <= 1'b0;
      release_pulse_reg    <= 1'b0;
      long_press_pulse_reg <= 1'b0;
      held_reg             <= 1'b0;
    end else begin
      // Strobes are high for exactly one cycle unless re-asserted below.
      press_pulse_reg      <= 1'b0;
      release_pulse_reg    <= 1'b0;
      long_press_pulse_reg <= 1'b0;

      case (state_reg)
        S_RELEASED: begin
          if (act) begin
            state_reg  <= S_PRESS_WAIT;
            db_cnt_reg <= '0;
          end
        end

        S_PRESS_WAIT: begin
          if (!act) begin
            // A bounce during the press is silently discarded.
            state_reg <= S_RELEASED;
          end else if (db_cnt_reg == DB_LAST) begin
            state_reg       <= S_PRESSED;
            press_pulse_reg <= 1'b1;
            pressed_reg     <= 1'b1;
            button_out_reg  <= ACTIVE_LEVEL;
            hold_cnt_reg    <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + CNT_ONE;
          end
        end

        S_PRESSED: begin
          if (!act) begin
            state_reg  <= S_RELEASE_WAIT;
            db_cnt_reg <= '0;
          end else if (!held_reg) begin
            // The long press fires once. After that, held keeps hold_cnt parked.
            if (hold_cnt_reg == HOLD_LAST) begin
              long_press_pulse_reg <= 1'b1;
              held_reg             <= 1'b1;
            end else begin
              hold_cnt_reg <= hold_cnt_reg + CNT_ONE;
            end
          end
        end

        S_RELEASE_WAIT: begin
          if (act) begin
            // A bounce during the release resumes the press with no strobe.
            state_reg <= S_PRESSED;
          end else if (db_cnt_reg == DB_LAST) begin
            state_reg         <= S_RELEASED;
            release_pulse_reg <= 1'b1;
            pressed_reg       <= 1'b0;
            held_reg          <= 1'b0;
            button_out_reg    <= IDLE_LEVEL;
          end else begin
            db_cnt_reg <= db_cnt_reg + CNT_ONE;
          end
        end

        default: begin
          state_reg <= S_RELEASED;
        end
      endcase
    end
  end

  assign button_out       = button_out_reg;
  assign pressed          = pressed_reg;
  assign press_pulse      = press_pulse_reg;
  assign release_pulse    = release_pulse_reg;
  assign long_press_pulse = long_press_pulse_reg;
  assign held             = held_reg;

endmodule
